// File: rtl/register_file.sv
// ============================================================================
//  Module      : register_file
//  Description : DEPTH x WIDTH register bank with one write port, two
//                tri-state read ports and a per-register busy scoreboard.
//                Define REGFILE_BYPASS_EN to forward write data/busy to reads.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module register_file #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter bit ZERO_REG = 1'b1,
    localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             issue_en,
    input  logic [AW-1:0]    issue_addr,
    input  logic             rd0_en,
    input  logic [AW-1:0]    rd0_addr,
    output logic [WIDTH-1:0] rd0_data,
    output logic             rd0_busy,
    input  logic             rd1_en,
    input  logic [AW-1:0]    rd1_addr,
    output logic [WIDTH-1:0] rd1_data,
    output logic             rd1_busy,
    output logic [DEPTH-1:0] busy_vec
);

    localparam bit c_POW2 = (DEPTH == (1 << AW));

    logic [WIDTH-1:0] r_regs [DEPTH];
    logic [DEPTH-1:0] r_busy;
    logic [DEPTH-1:0] w_busy_next;
    logic             w_wr_ok;
    logic             w_iss_ok;
    logic [WIDTH-1:0] w_rd0_val;
    logic [WIDTH-1:0] w_rd1_val;
    logic             w_rd0_busy;
    logic             w_rd1_busy;

    // An address is usable if it names a real register other than a hardwired zero.
    function automatic logic f_addr_ok(input logic [AW-1:0] addr);
        logic ok;
        ok = c_POW2 || (32'(addr) < DEPTH);
        if (ZERO_REG && (addr == '0)) ok = 1'b0;
        return ok;
    endfunction

    assign w_wr_ok  = wr_en && f_addr_ok(wr_addr);
    assign w_iss_ok = issue_en && f_addr_ok(issue_addr);

    // Claim is applied after release so a same-address issue wins over writeback.
    always_comb begin
        w_busy_next = r_busy;
        if (w_wr_ok)  w_busy_next[wr_addr]    = 1'b0;
        if (w_iss_ok) w_busy_next[issue_addr] = 1'b1;
    end

    always_ff @(negedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) r_regs[i] <= '0;
            r_busy <= '0;
        end else begin
            if (w_wr_ok) r_regs[wr_addr] <= wr_data;
            r_busy <= w_busy_next;
`ifndef SYNTHESIS
            if (wr_en) begin
                assert (!$isunknown(wr_data))
                    else $error("register_file: wr_data has X/Z bits during write");
            end
`endif
        end
    end

    always_comb begin
        w_rd0_val  = '0;
        w_rd0_busy = 1'b0;
        if (f_addr_ok(rd0_addr)) begin
            w_rd0_val = r_regs[rd0_addr];
`ifdef REGFILE_BYPASS_EN
            if (w_wr_ok && (wr_addr == rd0_addr)) w_rd0_val = wr_data;
            w_rd0_busy = w_busy_next[rd0_addr];
`else
            w_rd0_busy = r_busy[rd0_addr];
`endif
        end
    end

    always_comb begin
        w_rd1_val  = '0;
        w_rd1_busy = 1'b0;
        if (f_addr_ok(rd1_addr)) begin
            w_rd1_val = r_regs[rd1_addr];
`ifdef REGFILE_BYPASS_EN
            if (w_wr_ok && (wr_addr == rd1_addr)) w_rd1_val = wr_data;
            w_rd1_busy = w_busy_next[rd1_addr];
`else
            w_rd1_busy = r_busy[rd1_addr];
`endif
        end
    end

    assign rd0_data = rd0_en ? w_rd0_val : {WIDTH{1'bz}};
    assign rd1_data = rd1_en ? w_rd1_val : {WIDTH{1'bz}};
    assign rd0_busy = w_rd0_busy;
    assign rd1_busy = w_rd1_busy;
    assign busy_vec = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_register_file.sv
// ============================================================================
//  Module      : tb_register_file
//  Description : Randomised and directed checks of register_file against a
//                behavioural model; a second small instance covers DEPTH=12.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_register_file;

    logic        clk = 1'b1;
    logic        reset = 1'b0;
    logic        wr_en = 1'b0;
    logic [4:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic        issue_en = 1'b0;
    logic [4:0]  issue_addr = '0;
    logic        rd0_en = 1'b0;
    logic [4:0]  rd0_addr = '0;
    logic        rd1_en = 1'b0;
    logic [4:0]  rd1_addr = '0;
    wire  [31:0] rd0_data;
    wire  [31:0] rd1_data;
    logic        rd0_busy;
    logic        rd1_busy;
    logic [31:0] busy_vec;

    logic        p_reset = 1'b0;
    logic        p_wr_en = 1'b0;
    logic [3:0]  p_wr_addr = '0;
    logic [15:0] p_wr_data = '0;
    logic        p_issue_en = 1'b0;
    logic [3:0]  p_issue_addr = '0;
    logic        p_rd0_en = 1'b0;
    logic [3:0]  p_rd0_addr = '0;
    logic        p_rd1_en = 1'b0;
    logic [3:0]  p_rd1_addr = '0;
    wire  [15:0] p_rd0_data;
    wire  [15:0] p_rd1_data;
    logic        p_rd0_busy;
    logic        p_rd1_busy;
    logic [11:0] p_busy_vec;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    register_file u_dut (
        .clk(clk), .reset(reset),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .issue_en(issue_en), .issue_addr(issue_addr),
        .rd0_en(rd0_en), .rd0_addr(rd0_addr), .rd0_data(rd0_data), .rd0_busy(rd0_busy),
        .rd1_en(rd1_en), .rd1_addr(rd1_addr), .rd1_data(rd1_data), .rd1_busy(rd1_busy),
        .busy_vec(busy_vec)
    );

    register_file #(.WIDTH(16), .DEPTH(12), .ZERO_REG(1'b0)) u_small (
        .clk(clk), .reset(p_reset),
        .wr_en(p_wr_en), .wr_addr(p_wr_addr), .wr_data(p_wr_data),
        .issue_en(p_issue_en), .issue_addr(p_issue_addr),
        .rd0_en(p_rd0_en), .rd0_addr(p_rd0_addr), .rd0_data(p_rd0_data), .rd0_busy(p_rd0_busy),
        .rd1_en(p_rd1_en), .rd1_addr(p_rd1_addr), .rd1_data(p_rd1_data), .rd1_busy(p_rd1_busy),
        .busy_vec(p_busy_vec)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model of the 32x32 bank with register 0 hardwired to zero.
    logic [31:0] m_regs [32];
    logic        m_busy [32];
    bit          model_on = 1'b0;

    always @(negedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                m_regs[i] <= '0;
                m_busy[i] <= 1'b0;
            end
        end else begin
            if (wr_en && wr_addr != 0) begin
                m_regs[wr_addr] <= wr_data;
                m_busy[wr_addr] <= 1'b0;
            end
            if (issue_en && issue_addr != 0) m_busy[issue_addr] <= 1'b1;
        end
    end

    function automatic logic [31:0] exp_data(input logic [4:0] a);
        if (a == 0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
        if (wr_en && wr_addr == a) return wr_data;
`endif
        return m_regs[a];
    endfunction

    function automatic logic exp_busy(input logic [4:0] a);
        if (a == 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
        if (issue_en && issue_addr == a) return 1'b1;
        if (wr_en && wr_addr == a) return 1'b0;
`endif
        return m_busy[a];
    endfunction

    function automatic logic [31:0] exp_vec();
        logic [31:0] v;
        for (int i = 0; i < 32; i++) v[i] = m_busy[i];
        return v;
    endfunction

    // Mid-cycle comparison: inputs are stable and the falling edge is half a period away.
    always @(posedge clk) begin
        if (model_on) begin
            if (rd0_en) chk("rd0_data", rd0_data, exp_data(rd0_addr));
            else begin
                checks++;
                if (rd0_data !== 32'hzzzzzzzz) begin
                    failures++;
                    $display("FAIL rd0_data_z: got %h expected zzzzzzzz", rd0_data);
                end
            end
            if (rd1_en) chk("rd1_data", rd1_data, exp_data(rd1_addr));
            else begin
                checks++;
                if (rd1_data !== 32'hzzzzzzzz) begin
                    failures++;
                    $display("FAIL rd1_data_z: got %h expected zzzzzzzz", rd1_data);
                end
            end
            chk("rd0_busy", {31'b0, rd0_busy}, {31'b0, exp_busy(rd0_addr)});
            chk("rd1_busy", {31'b0, rd1_busy}, {31'b0, exp_busy(rd1_addr)});
            chk("busy_vec", busy_vec, exp_vec());
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [4:0] pick_addr();
        if ($urandom_range(0, 1) == 1) return 5'($urandom_range(0, 3));
        return 5'($urandom_range(0, 31));
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset both instances, then read back cleared state.
        reset = 1'b1;
        p_reset = 1'b1;
        tick();
        reset = 1'b0;
        p_reset = 1'b0;
        model_on = 1'b1;
        rd0_en = 1'b1;
        rd0_addr = 5'd5;
        rd1_en = 1'b0;
        #1;
        chk("reset_rd0_data", rd0_data, 32'h0);
        chk("reset_rd0_busy", {31'b0, rd0_busy}, 32'h0);
        chk("reset_busy_vec", busy_vec, 32'h0);
        checks++;
        if (rd1_data !== 32'hzzzzzzzz) begin
            failures++;
            $display("FAIL reset_rd1_z: got %h expected zzzzzzzz", rd1_data);
        end

        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hDEADBEEF;
        tick();
        wr_en = 1'b0;
        rd0_addr = 5'd7; rd1_en = 1'b1; rd1_addr = 5'd7;
        #1;
        chk("wr7_rd0", rd0_data, 32'hDEADBEEF);
        chk("wr7_rd1", rd1_data, 32'hDEADBEEF);

        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h1234;
        tick();
        wr_en = 1'b0;
        rd0_addr = 5'd0;
        #1;
        chk("wr0_dropped", rd0_data, 32'h0);

        // Scoreboard claim, release two cycles later, then simultaneous claim/write.
        issue_en = 1'b1; issue_addr = 5'd3;
        tick();
        issue_en = 1'b0;
        rd0_addr = 5'd3;
        #1;
        chk("issue3_busy", {31'b0, rd0_busy}, 32'h1);
        chk("issue3_vec", {31'b0, busy_vec[3]}, 32'h1);
        tick();
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h55;
        tick();
        wr_en = 1'b0;
        #1;
        chk("wb3_busy", {31'b0, rd0_busy}, 32'h0);
        chk("wb3_data", rd0_data, 32'h55);
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h66;
        issue_en = 1'b1; issue_addr = 5'd3;
        tick();
        wr_en = 1'b0; issue_en = 1'b0;
        #1;
        chk("same_edge_busy", {31'b0, rd0_busy}, 32'h1);
        chk("same_edge_data", rd0_data, 32'h66);

        // Read of the write address before the edge.
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h11111111;
        tick();
        wr_addr = 5'd9; wr_data = 32'hA5A5A5A5; rd0_addr = 5'd9;
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("bypass_data", rd0_data, 32'hA5A5A5A5);
        chk("bypass_busy", {31'b0, rd0_busy}, 32'h0);
`else
        chk("prewrite_data", rd0_data, 32'h11111111);
`endif
        tick();
        wr_en = 1'b0;
        #1;
        chk("postwrite_data", rd0_data, 32'hA5A5A5A5);

        // Reset in the middle of outstanding claims, with a write on the reset edge.
        for (int i = 1; i <= 4; i++) begin
            wr_en = 1'b1; wr_addr = 5'(i); wr_data = 32'(i * 256);
            issue_en = 1'b1; issue_addr = 5'(i);
            tick();
        end
        wr_en = 1'b0; issue_en = 1'b0;
        #1;
        chk("claims_vec", busy_vec & 32'h1E, 32'h1E);
        reset = 1'b1; wr_en = 1'b1; wr_addr = 5'd2; wr_data = 32'hFFFF;
        tick();
        reset = 1'b0; wr_en = 1'b0;
        #1;
        chk("midreset_vec", busy_vec, 32'h0);
        for (int i = 1; i <= 4; i++) begin
            rd0_addr = 5'(i);
            #1;
            chk("midreset_data", rd0_data, 32'h0);
        end

        // Non-power-of-two instance without a zero register.
        p_rd0_en = 1'b1;
        p_wr_en = 1'b1; p_wr_addr = 4'd0; p_wr_data = 16'hBEEF;
        tick();
        p_wr_addr = 4'd11; p_wr_data = 16'h0B0B;
        p_rd0_addr = 4'd0;
        #1;
        chk("small_reg0", {16'b0, p_rd0_data}, 32'hBEEF);
        tick();
        p_wr_addr = 4'd13; p_wr_data = 16'h1111;
        p_issue_en = 1'b1; p_issue_addr = 4'd13;
        tick();
        p_wr_en = 1'b0; p_issue_en = 1'b0;
        p_rd0_addr = 4'd13;
        #1;
        chk("small_oob_data", {16'b0, p_rd0_data}, 32'h0);
        chk("small_oob_busy", {31'b0, p_rd0_busy}, 32'h0);
        chk("small_oob_vec", {20'b0, p_busy_vec}, 32'h0);
        p_rd0_addr = 4'd11;
        #1;
        chk("small_reg11", {16'b0, p_rd0_data}, 32'h0B0B);

        // Randomised traffic, biased toward a few addresses so collisions are common.
        for (int n = 0; n < 2000; n++) begin
            reset      = ($urandom_range(0, 99) == 0);
            wr_en      = ($urandom_range(0, 1) == 1);
            wr_addr    = pick_addr();
            wr_data    = $urandom();
            issue_en   = ($urandom_range(0, 2) == 0);
            issue_addr = pick_addr();
            rd0_en     = ($urandom_range(0, 3) != 0);
            rd0_addr   = pick_addr();
            rd1_en     = ($urandom_range(0, 3) != 0);
            rd1_addr   = pick_addr();
            tick();
        end
        reset = 1'b0; wr_en = 1'b0; issue_en = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
